// File: rtl/bldc_hall_pkg.sv
// Shared constants and hall-code helpers for the BLDC hall-sensor capture block.
// Forward rotation walks the codes 1,3,2,6,4,5 and wraps back to 1.
package bldc_hall_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_W_DEF      = 4;
    localparam int PER_W_DEF       = 24;

    localparam logic [2:0] HALL_INV0 = 3'b000;
    localparam logic [2:0] HALL_INV1 = 3'b111;

    typedef enum logic {
        DIR_REV = 1'b0,
        DIR_FWD = 1'b1
    } hall_dir_e;

    function automatic logic hall_valid(input logic [2:0] code);
        return (code != HALL_INV0) && (code != HALL_INV1);
    endfunction

    function automatic logic [2:0] hall_fwd_next(input logic [2:0] code);
        case (code)
            3'd1:    return 3'd3;
            3'd3:    return 3'd2;
            3'd2:    return 3'd6;
            3'd6:    return 3'd4;
            3'd4:    return 3'd5;
            3'd5:    return 3'd1;
            default: return HALL_INV0;
        endcase
    endfunction

    function automatic logic [2:0] hall_rev_next(input logic [2:0] code);
        case (code)
            3'd1:    return 3'd5;
            3'd5:    return 3'd4;
            3'd4:    return 3'd6;
            3'd6:    return 3'd2;
            3'd2:    return 3'd3;
            3'd3:    return 3'd1;
            default: return HALL_INV0;
        endcase
    endfunction

endpackage

// File: rtl/bldc_hall_filt.sv
// Hall input synchroniser plus debounce filter: a candidate code is stable once
// it has been seen unchanged for at least filt_len_i extra cycles.
module bldc_hall_filt
    import bldc_hall_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        hall_i,
    input  logic [FILT_W-1:0] filt_len_i,
    output logic [2:0]        cand_o,
    output logic              stable_o,
    output logic              cand_chg_o
);

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  hall_s;
    logic [2:0]                  cand_q, cand_d;
    logic [FILT_W-1:0]           cnt_q, cnt_d;

    assign hall_s = sync_q[SYNC_STAGES-1];

    // The counter saturates so long filter settings never wrap back to "unstable".
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], hall_i};
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (hall_s != cand_q) begin
            cand_d = hall_s;
            cnt_d  = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cand_o     = cand_q;
    assign stable_o   = (hall_s == cand_q) && (cnt_q >= filt_len_i);
    assign cand_chg_o = (hall_s != cand_q);

endmodule

// File: rtl/bldc_hall_capture.sv
// BLDC hall-sensor front end: accepts debounced valid hall codes and reports
// commutation pulses, rotation direction, commutation period and stall.
module bldc_hall_capture
    import bldc_hall_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF,
    parameter int PER_W       = PER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        hall_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    output logic [2:0]        hall_o,
    output logic              hall_change_o,
    output logic              hall_err_o,
    output logic              dir_o,
    output logic [PER_W-1:0]  period_o,
    output logic              period_vld_o,
    output logic              stall_o
);

    logic [2:0]       cand;
    logic             stable;
    logic             cand_chg;

    logic [2:0]       hall_q, hall_d;
    hall_dir_e        dir_q, dir_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic             stall_q, stall_d;
    logic             err_flag_q, err_flag_d;
    logic             change_q, change_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;

    logic             have_prev, is_fwd, is_rev;
    logic             accept, inv_err, skip_err;

    bldc_hall_filt #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
    ) u_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .hall_i     (hall_i),
        .filt_len_i (filt_len_i),
        .cand_o     (cand),
        .stable_o   (stable),
        .cand_chg_o (cand_chg)
    );

    // hall_q==0 marks "no reference code yet" after reset or re-enable.
    assign have_prev = (hall_q != HALL_INV0);
    assign is_fwd    = (cand == hall_fwd_next(hall_q));
    assign is_rev    = (cand == hall_rev_next(hall_q));
    assign accept    = stable && hall_valid(cand) && (cand != hall_q) && en_i;
    assign inv_err   = stable && !hall_valid(cand) && !err_flag_q && en_i;
    assign skip_err  = accept && have_prev && !is_fwd && !is_rev;

    always_comb begin
        hall_d     = hall_q;
        dir_d      = dir_q;
        period_d   = period_q;
        per_cnt_d  = per_cnt_q;
        stall_d    = stall_q;
        err_flag_d = cand_chg ? 1'b0 : (err_flag_q || inv_err);
        change_d   = 1'b0;
        err_d      = inv_err || skip_err;
        vld_d      = 1'b0;
        if (!en_i) begin
            hall_d    = HALL_INV0;
            per_cnt_d = '0;
            stall_d   = 1'b0;
        end else if (accept) begin
            hall_d    = cand;
            per_cnt_d = '0;
            stall_d   = 1'b0;
            change_d  = 1'b1;
            if (have_prev) begin
                if (is_fwd) begin
                    dir_d = DIR_FWD;
                end else if (is_rev) begin
                    dir_d = DIR_REV;
                end
                // A stalled interval has no meaningful period to report.
                if (!stall_q) begin
                    period_d = per_cnt_q + PER_W'(1);
                    vld_d    = 1'b1;
                end
            end
        end else begin
            if (per_cnt_q != '1) begin
                per_cnt_d = per_cnt_q + PER_W'(1);
            end
            stall_d = stall_q || (per_cnt_d == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_q     <= HALL_INV0;
            dir_q      <= DIR_FWD;
            period_q   <= '0;
            per_cnt_q  <= '0;
            stall_q    <= 1'b0;
            err_flag_q <= 1'b0;
            change_q   <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            hall_q     <= hall_d;
            dir_q      <= dir_d;
            period_q   <= period_d;
            per_cnt_q  <= per_cnt_d;
            stall_q    <= stall_d;
            err_flag_q <= err_flag_d;
            change_q   <= change_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
        end
    end

    assign hall_o        = hall_q;
    assign hall_change_o = change_q;
    assign hall_err_o    = err_q;
    assign dir_o         = dir_q;
    assign period_o      = period_q;
    assign period_vld_o  = vld_q;
    assign stall_o       = stall_q;

endmodule

// File: tb/tb_bldc_hall_capture.sv
// Bench for bldc_hall_capture: directed scenarios plus randomized hall traffic,
// all checked against an edge-timestamp reference model of the capture rules.
module tb_bldc_hall_capture;

    localparam int SYNC = 2;
    localparam int PMAX = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] hall_i = 3'd1;
    logic       en_i = 1'b0;
    logic [3:0] filt_len_i = 4'd3;
    logic [2:0] hall_o;
    logic       hall_change_o, hall_err_o, dir_o, period_vld_o, stall_o;
    logic [7:0] period_o;

    int vectors = 0;
    int miscompares = 0;

    bldc_hall_capture #(
        .SYNC_STAGES (SYNC),
        .FILT_W      (4),
        .PER_W       (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hall_i        (hall_i),
        .en_i          (en_i),
        .filt_len_i    (filt_len_i),
        .hall_o        (hall_o),
        .hall_change_o (hall_change_o),
        .hall_err_o    (hall_err_o),
        .dir_o         (dir_o),
        .period_o      (period_o),
        .period_vld_o  (period_vld_o),
        .stall_o       (stall_o)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] RESET_VAL = {3'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};

    logic [2:0] seq_tab [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

    function automatic int pos_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (seq_tab[i] == c) return i;
        return -1;
    endfunction

    // Reference model: filter stability and period/stall timing are derived
    // from edge timestamps rather than from counters.
    logic [2:0] m_q[$];
    int         m_e = 0, m_cand_edge = 0, m_last_clear = 0, m_step;
    logic [2:0] m_cand = 3'd0, m_hs;
    bit         m_err_flag = 0, m_stable, m_valid, m_accept, m_inv, m_skip, m_vld;
    logic [2:0] exp_hall = 3'd0;
    logic       exp_chg = 0, exp_err = 0, exp_dir = 1, exp_vld = 0, exp_stall = 0;
    logic [7:0] exp_period = 8'd0;

    logic [15:0] obs, exp_v;
    assign obs   = {hall_o, hall_change_o, hall_err_o, dir_o, period_o, period_vld_o, stall_o};
    assign exp_v = {exp_hall, exp_chg, exp_err, exp_dir, exp_period, exp_vld, exp_stall};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(3'd0);
            m_cand = 3'd0; m_cand_edge = m_e; m_last_clear = m_e; m_err_flag = 0;
            exp_hall = 3'd0; exp_chg = 0; exp_err = 0; exp_dir = 1;
            exp_vld = 0; exp_stall = 0; exp_period = 8'd0;
        end else begin
            m_e++;
            m_hs     = m_q[0];
            m_stable = (m_hs == m_cand) && ((m_e - 1 - m_cand_edge) >= int'(filt_len_i));
            m_valid  = (m_cand != 3'd0) && (m_cand != 3'd7);
            m_accept = m_stable && m_valid && (m_cand != exp_hall) && en_i;
            m_inv    = m_stable && !m_valid && !m_err_flag && en_i;
            m_skip   = 0;
            m_vld    = 0;
            if (m_accept && exp_hall != 3'd0) begin
                m_step = (pos_of(m_cand) - pos_of(exp_hall) + 6) % 6;
                if (m_step == 1) exp_dir = 1'b1;
                else if (m_step == 5) exp_dir = 1'b0;
                else m_skip = 1;
                if ((m_e - 1 - m_last_clear) < PMAX) begin
                    m_vld = 1;
                    exp_period = 8'(m_e - m_last_clear);
                end
            end
            exp_chg = m_accept;
            exp_err = m_inv || m_skip;
            exp_vld = m_vld;
            if (!en_i) begin
                exp_hall = 3'd0; exp_stall = 0; m_last_clear = m_e;
            end else if (m_accept) begin
                exp_hall = m_cand; exp_stall = 0; m_last_clear = m_e;
            end else begin
                exp_stall = (m_e - m_last_clear) >= PMAX;
            end
            if (m_hs != m_cand) begin
                m_cand = m_hs; m_cand_edge = m_e; m_err_flag = 0;
            end else if (m_inv) begin
                m_err_flag = 1;
            end
            m_q.push_back(hall_i);
            void'(m_q.pop_front());
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; en_i = 1'b0; hall_i = 3'd1; filt_len_i = 4'd3;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== RESET_VAL) begin
            miscompares++;
            $display("[TB] FAIL reset_values got=%h want=%h", obs, RESET_VAL);
        end
        rst_n = 1'b1; en_i = 1'b1;
    endtask

    task automatic test_forward();
        logic [2:0] steps [6];
        logic [2:0] prev;
        int chg_cnt = 0;
        steps = '{3'd3, 3'd2, 3'd6, 3'd4, 3'd5, 3'd1};
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL fwd_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (hall_change_o) chg_cnt++;
        end
        prev = 3'd1;
        for (int s = 0; s < 6; s++) begin
            hall_i = steps[s];
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                vectors++;
                if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL fwd_model t=%0t got=%h want=%h", $time, obs, exp_v); end
                if (hall_change_o) chg_cnt++;
                if (k == 6) begin
                    vectors++;
                    if (hall_o !== prev) begin miscompares++; $display("[TB] FAIL fwd_early got=%0d want=%0d", hall_o, prev); end
                end
                if (k == 7) begin
                    vectors++;
                    if ({hall_o, hall_change_o, dir_o, period_vld_o, period_o} !== {steps[s], 1'b1, 1'b1, 1'b1, 8'd40}) begin
                        miscompares++;
                        $display("[TB] FAIL fwd_step hall=%0d chg=%b dir=%b vld=%b per=%0d want hall=%0d chg=1 dir=1 vld=1 per=40",
                                 hall_o, hall_change_o, dir_o, period_vld_o, period_o, steps[s]);
                    end
                end
            end
            prev = steps[s];
        end
        vectors++;
        if (chg_cnt != 7) begin miscompares++; $display("[TB] FAIL fwd_change_count got=%0d want=7", chg_cnt); end
    endtask

    task automatic test_reverse();
        logic [2:0] steps [2];
        int err_cnt = 0;
        steps = '{3'd5, 3'd4};
        for (int s = 0; s < 2; s++) begin
            hall_i = steps[s];
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                vectors++;
                if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL rev_model t=%0t got=%h want=%h", $time, obs, exp_v); end
                if (hall_err_o) err_cnt++;
                if (k == 7) begin
                    vectors++;
                    if ({hall_o, hall_change_o, dir_o} !== {steps[s], 1'b1, 1'b0}) begin
                        miscompares++;
                        $display("[TB] FAIL rev_step hall=%0d chg=%b dir=%b want hall=%0d chg=1 dir=0", hall_o, hall_change_o, dir_o, steps[s]);
                    end
                end
            end
        end
        vectors++;
        if (err_cnt != 0) begin miscompares++; $display("[TB] FAIL rev_err_count got=%0d want=0", err_cnt); end
    endtask

    task automatic test_glitch();
        int chg_cnt = 0;
        hall_i = 3'd6;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL glitch_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (hall_change_o) chg_cnt++;
            if (k == 2) hall_i = 3'd4;
        end
        vectors++;
        if ({chg_cnt != 0, hall_o} !== {1'b0, 3'd4}) begin
            miscompares++;
            $display("[TB] FAIL glitch_reject changes=%0d hall=%0d want changes=0 hall=4", chg_cnt, hall_o);
        end
    endtask

    task automatic test_invalid_skip();
        int err_cnt = 0;
        hall_i = 3'd7;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL inv_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (hall_err_o) err_cnt++;
        end
        vectors++;
        if (err_cnt != 1 || hall_o !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL inv_single_err errs=%0d hall=%0d want errs=1 hall=4", err_cnt, hall_o);
        end
        hall_i = 3'd1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL inv_model t=%0t got=%h want=%h", $time, obs, exp_v); end
        end
        hall_i = 3'd6;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL skip_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (k == 7) begin
                vectors++;
                if ({hall_o, hall_change_o, hall_err_o, dir_o} !== {3'd6, 1'b1, 1'b1, 1'b0}) begin
                    miscompares++;
                    $display("[TB] FAIL skip_step hall=%0d chg=%b err=%b dir=%b want 6 1 1 0", hall_o, hall_change_o, hall_err_o, dir_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL stall_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (k == 221 || k == 222) begin
                vectors++;
                if (stall_o !== (k == 222)) begin
                    miscompares++;
                    $display("[TB] FAIL stall_onset k=%0d got=%b want=%b", k, stall_o, (k == 222));
                end
            end
        end
        hall_i = 3'd4;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL stall_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (k == 7) begin
                vectors++;
                if ({hall_o, hall_change_o, stall_o, period_vld_o, dir_o} !== {3'd4, 1'b1, 1'b0, 1'b0, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_clear hall=%0d chg=%b stall=%b vld=%b dir=%b want 4 1 0 0 1",
                             hall_o, hall_change_o, stall_o, period_vld_o, dir_o);
                end
            end
        end
        hall_i = 3'd5;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL stall_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (k == 7) begin
                vectors++;
                if ({period_vld_o, period_o} !== {1'b1, 8'd40}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_next_period vld=%b per=%0d want vld=1 per=40", period_vld_o, period_o);
                end
            end
        end
    endtask

    task automatic test_enable();
        int pulse_cnt = 0;
        hall_i = 3'd1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL en_model t=%0t got=%h want=%h", $time, obs, exp_v); end
        end
        en_i = 1'b0;
        hall_i = 3'd5;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL dis_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            pulse_cnt += int'(hall_change_o) + int'(hall_err_o) + int'(period_vld_o);
            if (k == 1) begin
                vectors++;
                if (hall_o !== 3'd0) begin miscompares++; $display("[TB] FAIL dis_hall got=%0d want=0", hall_o); end
            end
        end
        vectors++;
        if (pulse_cnt != 0) begin miscompares++; $display("[TB] FAIL dis_pulses got=%0d want=0", pulse_cnt); end
        en_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL reen_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (k == 1) begin
                vectors++;
                if ({hall_o, hall_change_o, period_vld_o, hall_err_o, dir_o} !== {3'd5, 1'b1, 1'b0, 1'b0, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL reen_first hall=%0d chg=%b vld=%b err=%b dir=%b want 5 1 0 0 1",
                             hall_o, hall_change_o, period_vld_o, hall_err_o, dir_o);
                end
            end
        end
        hall_i = 3'd1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL reen_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (k == 7) begin
                vectors++;
                if ({period_vld_o, period_o, dir_o} !== {1'b1, 8'd46, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL reen_period vld=%b per=%0d dir=%b want vld=1 per=46 dir=1", period_vld_o, period_o, dir_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        hall_i = 3'd3;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== RESET_VAL || obs !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL async_reset got=%h want=%h", obs, RESET_VAL);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL rst_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            if (k == 6 || k == 7) begin
                vectors++;
                if (hall_o !== ((k == 7) ? 3'd3 : 3'd0)) begin
                    miscompares++;
                    $display("[TB] FAIL rst_requalify k=%0d hall=%0d want=%0d", k, hall_o, (k == 7) ? 3 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int r;
        for (int seg = 0; seg < 40; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 10) hall_i = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
            else hall_i = seq_tab[$urandom_range(0, 5)];
            hold = (r >= 96) ? 270 : $urandom_range(1, 45);
            if ($urandom_range(0, 5) == 0) filt_len_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) en_i = ~en_i;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                vectors++;
                if (obs !== exp_v) begin miscompares++; $display("[TB] FAIL random_model t=%0t got=%h want=%h", $time, obs, exp_v); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_invalid_skip();
        test_stall();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bldc_hall_capture.md
Name: bldc_hall_capture

Overview:
Parametrised hall-sensor front end for the BLDC controller. It synchronises and debounces the 3-bit hall input with a runtime-programmable filter length, and rejects invalid codes. For each accepted commutation it reports a change pulse, the rotation direction and the period since the previous change, and it flags stalls. It sits between the hall input pads and the BLDC commutation and register logic.

Parameters:
SYNC_STAGES, 2, number of input synchroniser flops (>=2)
FILT_W, 4, width of the debounce length and counter
PER_W, 24, width of the period counter and period output

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
hall_i  input  3  raw hall sensor inputs {C,B,A}
en_i  input  1  capture enable
filt_len_i  input  FILT_W  extra stable cycles required before accept
hall_o  output  3  last accepted valid hall code
hall_change_o  output  1  one-cycle pulse, hall_o updated
hall_err_o  output  1  one-cycle pulse, invalid code or non-adjacent step
dir_o  output  1  1 = forward, 0 = reverse
period_o  output  PER_W  clk cycles between the last two accepts
period_vld_o  output  1  one-cycle pulse, period_o updated
stall_o  output  1  level, no accept for 2^PER_W-1 cycles

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. All flops are in the clk domain.
- Reset values: hall_o=0, dir_o=1, period_o=0, stall_o=0, all pulses 0, synchroniser=0, cand=0, cnt=0.
- Synchroniser: hall_s = hall_i delayed by SYNC_STAGES flops.
- Filter:
  - hall_s!=cand: cand<=hall_s, cnt<=0.
  - Otherwise cnt increments, saturating at all-ones.
  - stable = (hall_s==cand) & (cnt>=filt_len_i).
  - A change of filt_len_i takes effect immediately.
- Latency: a clean hall_i step appears on hall_o after SYNC_STAGES+2+filt_len_i clock edges. Example: 7 edges with SYNC_STAGES=2 and filt_len_i=3.
- Invalid codes are 000 and 111.
  - A stable invalid cand gives one hall_err_o pulse per episode. A flag is set on the pulse and cleared when cand changes.
  - hall_o, dir_o and the period logic are unaffected.
- Accept: stable & valid(cand) & cand!=hall_o & en_i. On the next edge:
  - hall_o<=cand.
  - hall_change_o=1 for one cycle.
- Forward sequence is 1,3,2,6,4,5 and wraps 5->1. Reverse is the opposite order. At accept, with hall_o!=0:
  - Forward successor: dir_o<=1.
  - Reverse successor: dir_o<=0.
  - Otherwise (skipped step): dir_o held, hall_err_o pulses, hall_o still updates.
- First accept after reset or after enable (hall_o==0): no dir update, no err, no period_vld_o. per_cnt restarts.
- Period counter per_cnt:
  - Increments every enabled cycle, saturating at all-ones.
  - Cleared to 0 on accept.
  - At accept with hall_o!=0 and stall_o=0: period_o<=per_cnt+1 and period_vld_o pulses. period_o equals the edge distance between consecutive accepts.
- Stall:
  - stall_o<=1 when per_cnt reaches all-ones.
  - Cleared on the next accept. That accept does not pulse period_vld_o and leaves period_o unchanged.
- en_i=0:
  - Synchroniser and filter keep running; no accepts.
  - hall_o<=0, per_cnt<=0, stall_o<=0.
  - dir_o and period_o held.
  - Pulses are forced to 0 from the next cycle.
- Simultaneous events: err and change can pulse in the same cycle (skip). Accept and stall saturation in the same cycle resolve to accept: counter cleared, stall_o=0.
- Reset mid-operation returns everything to reset values immediately. The filter then re-qualifies from scratch.

Decomposition:
- Package bldc_hall_pkg:
  - HALL_INV0=3'b000, HALL_INV1=3'b111.
  - Function hall_fwd_next(code) and function hall_rev_next(code), as lookups over the 1,3,2,6,4,5 sequence.
  - Default parameter constants.
- Sub-module bldc_hall_filt: synchroniser plus debounce counter, outputs cand and stable.
- The top level holds the accept, direction, period and stall logic.

Test Plan:
- Clean forward rotation: hall_i 1->3->2->6->4->5->1, 40 cycles apart, filt_len_i=3 -> hall_o follows each step 7 edges after the input; dir_o=1; hall_change_o one pulse per step; period_o=40 from the 2nd accept on.
- Reverse rotation: 1->5->4 -> dir_o goes to 0 at 5 (the 2nd accept) and stays 0; no hall_err_o.
- Glitch rejection: hall_i 1->3 for 2 cycles then back to 1, filt_len_i=3 -> hall_o stays 1; no change pulse.
- Invalid and skip codes: hall_i=7 held 20 cycles -> exactly one hall_err_o, hall_o unchanged. Then a 1->6 jump -> hall_err_o and hall_change_o in the same cycle, hall_o=6, dir_o unchanged.
- Stall, with PER_W=8: no change for 300 cycles -> stall_o=1 after 255 cycles. The next step clears stall_o, gives no period_vld_o, and the following step gives the correct period.
- Enable/reset: drop en_i mid-rotation -> hall_o=0 and pulses stop. Re-enable -> first accept has no dir or period update. Assert rst_n low mid-filter -> all outputs return to reset values asynchronously.
